l1d_cache: RTL and testbench

Direct-mapped, write-through, no-write-allocate L1 data cache between the CPU load/store stage and the memory controller's L1D port. It issues `mem_read`/`mem_write` requests toward the controller and honours the controller's `stall_l1d`. It returns load data to the CPU and stalls the CPU on misses and on all stores. Addresses with bit 31 set are peripheral space: they are never cached and always go to memory.

---
 rtl/l1d_cache_if.sv | 29 ++
 rtl/l1d_cache.sv | 118 +++++++++++
 tb/tb_l1d_cache.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/l1d_cache_if.sv
// CPU-side and memory-side signal bundle of the L1 data cache.
// Handshake: a CPU request (cpu_read/cpu_write) is held stable while cpu_stall is high
// and completes in the first cycle it is sampled with cpu_stall low; a memory request
// (mem_read/mem_write) is accepted in the first cycle it is high with mem_stall low,
// and read data arrives on mem_data in the cycle after that acceptance.
interface l1d_cache_if;
    logic [31:0] cpu_address;
    logic [31:0] cpu_write_data;
    logic        cpu_read;
    logic        cpu_write;
    logic [31:0] cpu_read_data;
    logic        cpu_stall;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_data;
    logic        mem_stall;

    modport master (
        output cpu_address, cpu_write_data, cpu_read, cpu_write, mem_data, mem_stall,
        input  cpu_read_data, cpu_stall, mem_address, mem_write_data, mem_read, mem_write
    );

    modport slave (
        input  cpu_address, cpu_write_data, cpu_read, cpu_write, mem_data, mem_stall,
        output cpu_read_data, cpu_stall, mem_address, mem_write_data, mem_read, mem_write
    );
endinterface

// File: rtl/l1d_cache.sv
// Direct-mapped, write-through, no-write-allocate L1 data cache with one-word lines.
// Addresses with bit 31 set bypass the cache and always go to memory.
module l1d_cache #(
    parameter int LINES = 8
) (
    input  logic        clock,
    input  logic        reset,
    l1d_cache_if.slave  bus,
    output logic [1:0]  dbg_state
);
    localparam int IDX  = $clog2(LINES);
    localparam int TAGW = 30 - IDX;

    typedef enum logic [1:0] {IDLE, READ_REQ, READ_WAIT, WRITE_REQ} state_t;

    state_t            state, state_next;
    logic [31:0]       req_addr, req_data;
    logic              latch_req;
    logic [LINES-1:0]  valid_q;
    logic [TAGW-1:0]   tag_q  [LINES];
    logic [31:0]       data_q [LINES];

    logic [IDX-1:0]    cpu_idx, req_idx;
    logic [TAGW-1:0]   cpu_tag, req_tag;
    logic              cpu_hit, req_hit, req_cacheable;

    logic [31:0]       cpu_read_data, mem_address, mem_write_data;
    logic              cpu_stall, mem_read, mem_write;

    assign cpu_idx       = bus.cpu_address[2+IDX-1:2];
    assign cpu_tag       = bus.cpu_address[31:2+IDX];
    assign req_idx       = req_addr[2+IDX-1:2];
    assign req_tag       = req_addr[31:2+IDX];
    assign cpu_hit       = ~bus.cpu_address[31] & valid_q[cpu_idx] & (tag_q[cpu_idx] == cpu_tag);
    assign req_cacheable = ~req_addr[31];
    assign req_hit       = req_cacheable & valid_q[req_idx] & (tag_q[req_idx] == req_tag);

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            req_addr <= '0;
            req_data <= '0;
        end else begin
            state <= state_next;
            if (latch_req) begin
                req_addr <= bus.cpu_address;
                req_data <= bus.cpu_write_data;
            end
        end
    end

    // Line storage: only the valid bits need resetting, tag/data are qualified by them.
    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q <= '0;
        end else if (state == READ_WAIT && req_cacheable) begin
            valid_q[req_idx] <= 1'b1;
            tag_q[req_idx]   <= req_tag;
            data_q[req_idx]  <= bus.mem_data;
        end else if (state == WRITE_REQ && !bus.mem_stall && req_hit) begin
            data_q[req_idx]  <= req_data;
        end
    end

    always_comb begin
        state_next     = state;
        latch_req      = 1'b0;
        cpu_stall      = 1'b0;
        cpu_read_data  = '0;
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        mem_address    = '0;
        mem_write_data = '0;
        case (state)
            IDLE: begin
                if (bus.cpu_write) begin
                    cpu_stall  = 1'b1;
                    latch_req  = 1'b1;
                    state_next = WRITE_REQ;
                end else if (bus.cpu_read) begin
                    if (cpu_hit) begin
                        cpu_read_data = data_q[cpu_idx];
                    end else begin
                        cpu_stall  = 1'b1;
                        latch_req  = 1'b1;
                        state_next = READ_REQ;
                    end
                end
            end
            READ_REQ: begin
                mem_read    = 1'b1;
                mem_address = req_addr;
                cpu_stall   = 1'b1;
                if (!bus.mem_stall) state_next = READ_WAIT;
            end
            READ_WAIT: begin
                cpu_read_data = bus.mem_data;
                state_next    = IDLE;
            end
            WRITE_REQ: begin
                mem_write      = 1'b1;
                mem_address    = req_addr;
                mem_write_data = req_data;
                cpu_stall      = bus.mem_stall;
                if (!bus.mem_stall) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign bus.cpu_read_data  = cpu_read_data;
    assign bus.cpu_stall      = cpu_stall;
    assign bus.mem_address    = mem_address;
    assign bus.mem_write_data = mem_write_data;
    assign bus.mem_read       = mem_read;
    assign bus.mem_write      = mem_write;
    assign dbg_state          = state;
endmodule

// File: tb/tb_l1d_cache.sv
// Directed bench for l1d_cache: load/store sequences checked against a scoreboard queue.
module tb_l1d_cache;
  logic       clock;
  logic       reset;
  logic [1:0] dbg_state;

  l1d_cache_if bus ();

  l1d_cache #(.LINES(8)) dut (
    .clock     (clock),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  int vectors = 0;
  int errors  = 0;
  logic [31:0] exp_q[$];
  logic [63:0] wexp_q[$];

  // clock/reset block
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic do_read(input string tag, input logic [31:0] addr, input logic [31:0] mem_val,
                         input int nstall, input logic [31:0] exp_data,
                         input int exp_stalls, input int exp_mrd);
    int stalls = 0;
    int mrds   = 0;
    int left   = nstall;
    bit done   = 0;
    bus.cpu_read    = 1'b1;
    bus.cpu_write   = 1'b0;
    bus.cpu_address = addr;
    bus.mem_data    = mem_val;
    bus.mem_stall   = (left > 0);
    exp_q.push_back(exp_data);
    for (int cyc = 0; cyc < 50 && !done; cyc++) begin
      @(negedge clock);
      check({tag, "_excl"}, {31'd0, bus.mem_read & bus.mem_write}, 32'd0);
      if (bus.mem_read) begin
        mrds++;
        check({tag, "_maddr"}, bus.mem_address, addr);
        if (bus.mem_stall) left--;
      end
      if (bus.cpu_stall) stalls++;
      else begin
        done = 1;
        check({tag, "_data"}, bus.cpu_read_data, exp_q.pop_front());
      end
      @(posedge clock);
      #1;
      bus.mem_stall = (left > 0);
    end
    bus.cpu_read  = 1'b0;
    bus.mem_stall = 1'b0;
    check({tag, "_done"}, {31'd0, done}, 32'd1);
    check({tag, "_stalls"}, stalls, exp_stalls);
    check({tag, "_mrd"}, mrds, exp_mrd);
  endtask

  task automatic do_write(input string tag, input logic [31:0] addr, input logic [31:0] data,
                          input int nstall, input int exp_stalls, input int exp_mw);
    int stalls = 0;
    int mws    = 0;
    int left   = nstall;
    bit done   = 0;
    logic [63:0] w;
    bus.cpu_read       = 1'b0;
    bus.cpu_write      = 1'b1;
    bus.cpu_address    = addr;
    bus.cpu_write_data = data;
    bus.mem_stall      = (left > 0);
    wexp_q.push_back({addr, data});
    for (int cyc = 0; cyc < 50 && !done; cyc++) begin
      @(negedge clock);
      check({tag, "_excl"}, {31'd0, bus.mem_read & bus.mem_write}, 32'd0);
      if (bus.mem_write) begin
        mws++;
        w = wexp_q[0];
        check({tag, "_maddr"}, bus.mem_address, w[63:32]);
        check({tag, "_mdata"}, bus.mem_write_data, w[31:0]);
        if (bus.mem_stall) left--;
      end
      if (bus.cpu_stall) stalls++;
      else begin
        done = 1;
        void'(wexp_q.pop_front());
      end
      @(posedge clock);
      #1;
      bus.mem_stall = (left > 0);
    end
    bus.cpu_write = 1'b0;
    bus.mem_stall = 1'b0;
    check({tag, "_done"}, {31'd0, done}, 32'd1);
    check({tag, "_stalls"}, stalls, exp_stalls);
    check({tag, "_mw"}, mws, exp_mw);
  endtask

  initial begin
    reset              = 1'b1;
    bus.cpu_address    = '0;
    bus.cpu_write_data = '0;
    bus.cpu_read       = 1'b0;
    bus.cpu_write      = 1'b0;
    bus.mem_data       = '0;
    bus.mem_stall      = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;

    @(negedge clock);
    check("rst_state", {30'd0, dbg_state}, 32'd0);
    check("rst_stall", {31'd0, bus.cpu_stall}, 32'd0);
    check("rst_mrd", {31'd0, bus.mem_read}, 32'd0);
    check("rst_mw", {31'd0, bus.mem_write}, 32'd0);
    check("rst_rdata", bus.cpu_read_data, 32'd0);
    check("rst_maddr", bus.mem_address, 32'd0);
    check("rst_mwdata", bus.mem_write_data, 32'd0);
    @(posedge clock);
    #1;

    // cold miss, then hit
    do_read("cold_miss", 32'h0000_0104, 32'hDEAD_BEEF, 0, 32'hDEAD_BEEF, 2, 1);
    do_read("hit", 32'h0000_0104, 32'h1111_1111, 0, 32'hDEAD_BEEF, 0, 0);

    // write hit updates the line
    do_write("wr_hit", 32'h0000_0104, 32'h1234_5678, 0, 1, 1);
    do_read("rd_after_wr", 32'h0000_0104, 32'h2222_2222, 0, 32'h1234_5678, 0, 0);

    // write miss does not allocate
    do_write("wr_miss", 32'h0000_0200, 32'hA5A5_A5A5, 0, 1, 1);
    do_read("rd_noalloc", 32'h0000_0200, 32'h0BAD_F00D, 0, 32'h0BAD_F00D, 2, 1);
    do_read("rd_filled", 32'h0000_0200, 32'h3333_3333, 0, 32'h0BAD_F00D, 0, 0);

    // uncached space
    do_read("unc1", 32'h8000_0000, 32'hCAFE_0001, 0, 32'hCAFE_0001, 2, 1);
    do_read("unc2", 32'h8000_0000, 32'hCAFE_0002, 0, 32'hCAFE_0002, 2, 1);
    do_read("unc_keep", 32'h0000_0104, 32'h4444_4444, 0, 32'h1234_5678, 0, 0);
    do_write("unc_wr", 32'h8000_0010, 32'h0000_0055, 2, 3, 3);

    // controller stall during READ_REQ; 0x124 conflicts with 0x104
    do_read("mstall", 32'h0000_0124, 32'h7777_7777, 3, 32'h7777_7777, 5, 4);
    do_read("evicted", 32'h0000_0104, 32'h9999_0000, 0, 32'h9999_0000, 2, 1);

    // reset in the middle of a miss
    bus.cpu_read    = 1'b1;
    bus.cpu_address = 32'h0000_0108;
    bus.mem_data    = 32'h5555_5555;
    bus.mem_stall   = 1'b1;
    @(negedge clock);
    check("rmid_stall", {31'd0, bus.cpu_stall}, 32'd1);
    @(posedge clock);
    #1;
    @(negedge clock);
    check("rmid_mrd_on", {31'd0, bus.mem_read}, 32'd1);
    check("rmid_state_rq", {30'd0, dbg_state}, 32'd1);
    reset        = 1'b1;
    bus.cpu_read = 1'b0;
    @(posedge clock);
    #1;
    reset         = 1'b0;
    bus.mem_stall = 1'b0;
    @(negedge clock);
    check("rmid_mrd_off", {31'd0, bus.mem_read}, 32'd0);
    check("rmid_state", {30'd0, dbg_state}, 32'd0);
    check("rmid_cstall", {31'd0, bus.cpu_stall}, 32'd0);
    @(posedge clock);
    #1;
    do_read("post_rst", 32'h0000_0104, 32'h6666_6666, 0, 32'h6666_6666, 2, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
